// File: rtl/pid_pkg.sv
// pid_pkg: shared constants and helpers for the pid_steer steering controller.
//   P_COEFF, D_COEFF : proportional / derivative gains
//   ERR_W            : width of the saturated error sample
//   DIFF_W           : width of the saturated derivative difference
//   SPD_W            : width of the signed wheel speed commands
//   sat()            : clamp a signed value into a w-bit two's complement range
package pid_pkg;

    localparam int P_COEFF = 3;
    localparam int D_COEFF = 6;

    localparam int ERR_W  = 10;
    localparam int DIFF_W = 7;
    localparam int SPD_W  = 11;

    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/pid_steer_i_term.sv
// pid_i_term: saturating-by-hold integrator for the steering PID.
// Present only when the macro PID_I_TERM_EN is defined.
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : run enable; low clears the integrator
//   vld        : sample strobe (stage-1 valid)
//   err_q      : signed 10-bit stage-1 error
//   i_term     : integrator >>> 4, signed 12-bit
`ifdef PID_I_TERM_EN
module pid_i_term
    import pid_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic                    vld,
    input  logic signed [ERR_W-1:0] err_q,
    output logic signed [11:0]      i_term
);

    logic signed [15:0] integ;
    logic signed [15:0] integ_sum;
    logic               ovf;

    assign integ_sum = integ + 16'(err_q);
    // Overflow only possible when both operands share a sign and the result flips it.
    assign ovf = (integ[15] == err_q[ERR_W-1]) && (integ_sum[15] != integ[15]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ <= '0;
        end else if (!go) begin
            integ <= '0;
        end else if (vld && !ovf) begin
            integ <= integ_sum;
        end
    end

    assign i_term = 12'(integ >>> 4);

endmodule
`endif

// File: rtl/pid_steer.sv
// pid_steer: closed-loop steering controller.
// Selects line-sensor or open-loop error, runs it through a saturating
// P/I/D pipeline, ramps forward speed while go is high and produces
// signed left/right wheel speeds.
// Optional integrator: define PID_I_TERM_EN to include it (I = 0 otherwise).
// Parameters: FAST_SIM (nonzero -> ramp step 4 instead of 1), FRWRD_MAX (ramp ceiling)
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   err_vld        : one-cycle strobe, new error sample
//   error          : signed 16-bit line-sensor error
//   err_opn_lp     : signed 16-bit open-loop override error
//   line_present   : 1 selects error, 0 selects err_opn_lp
//   go             : run enable
//   moving         : forward speed is nonzero
//   lft_spd        : signed 11-bit left wheel speed
//   rght_spd       : signed 11-bit right wheel speed
module pid_steer
    import pid_pkg::*;
#(
    parameter int         FAST_SIM  = 0,
    parameter logic [9:0] FRWRD_MAX = 10'h300
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    err_vld,
    input  logic signed [15:0]      error,
    input  logic signed [15:0]      err_opn_lp,
    input  logic                    line_present,
    input  logic                    go,
    output logic                    moving,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd
);

    localparam logic [10:0] INC = (FAST_SIM != 0) ? 11'd4 : 11'd1;

    logic signed [15:0]      err_sel;
    logic signed [ERR_W-1:0] err_sat;
    logic signed [ERR_W-1:0] err_q;
    logic                    vld_q;
    logic signed [ERR_W-1:0] hist_new;
    logic signed [ERR_W-1:0] hist_old;
    logic signed [10:0]      diff_raw;
    logic signed [13:0]      p_term;
    logic signed [12:0]      d_term;
    logic signed [11:0]      i_term;
    logic signed [14:0]      pid_sum;
    logic signed [14:0]      steer;
    logic [9:0]              frwrd;
    logic [10:0]             frwrd_sum;
    logic [9:0]              frwrd_nxt;
    logic signed [31:0]      lft_raw;
    logic signed [31:0]      rght_raw;

    assign err_sel = line_present ? error : err_opn_lp;
    assign err_sat = ERR_W'(sat(32'(err_sel), ERR_W));

    // ---- stage 1: sample register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= err_vld;
            if (err_vld) err_q <= err_sat;
        end
    end

    // ---- stage 2: PID terms and output register ----
    assign p_term   = 14'(err_q) * 14'(P_COEFF);
    assign diff_raw = 11'(err_q) - 11'(hist_old);
    assign d_term   = 13'(sat(32'(diff_raw), DIFF_W)) * 13'(D_COEFF);

`ifdef PID_I_TERM_EN
    pid_i_term u_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .vld    (vld_q),
        .err_q  (err_q),
        .i_term (i_term)
    );
`else
    assign i_term = '0;
`endif

    assign pid_sum = 15'(p_term) + 15'(i_term) + 15'(d_term);
    assign steer   = pid_sum >>> 3;

    assign frwrd_sum = {1'b0, frwrd} + INC;
    assign frwrd_nxt = (frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_sum[9:0];

    // Outputs use the ramped speed of this same sample.
    assign lft_raw  = $signed({22'd0, frwrd_nxt}) + 32'(steer);
    assign rght_raw = $signed({22'd0, frwrd_nxt}) - 32'(steer);

    // go low has priority over a coincident sample: everything clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_new <= '0;
            hist_old <= '0;
            frwrd    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else if (!go) begin
            hist_new <= '0;
            hist_old <= '0;
            frwrd    <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else if (vld_q) begin
            hist_old <= hist_new;
            hist_new <= err_q;
            frwrd    <= frwrd_nxt;
            lft_spd  <= SPD_W'(sat(lft_raw, SPD_W));
            rght_spd <= SPD_W'(sat(rght_raw, SPD_W));
        end
    end

    assign moving = (frwrd != '0);

endmodule

// File: tb/tb_pid_steer.sv
// tb_pid_steer: directed + randomized bench for pid_steer with a
// behavioural reference model. Define PID_I_TERM_EN to build both the
// design and the model with the integrator.
module tb_pid_steer;

    localparam logic [9:0] FMAX = 10'h300;
    localparam int INC = 1;
`ifdef PID_I_TERM_EN
    localparam bit I_EN = 1'b1;
`else
    localparam bit I_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_vld = 1'b0;
    logic line_present = 1'b1;
    logic go = 1'b0;
    logic signed [15:0] error = '0;
    logic signed [15:0] err_opn_lp = '0;
    logic moving;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;

    always #5 clk = ~clk;

    pid_steer #(.FAST_SIM(0), .FRWRD_MAX(FMAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .err_vld      (err_vld),
        .error        (error),
        .err_opn_lp   (err_opn_lp),
        .line_present (line_present),
        .go           (go),
        .moving       (moving),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int m_errq;
    bit m_vldq;
    int m_hist[$];
    int m_frwrd;
    int m_integ;
    int m_lft;
    int m_rght;

    function automatic int msat(int v, int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_reset();
        m_errq = 0; m_vldq = 0; m_hist = '{0, 0};
        m_frwrd = 0; m_integ = 0; m_lft = 0; m_rght = 0;
    endtask

    task automatic model_step(input bit v, input bit g, input bit lp, input int e, input int o);
        int p, d, i, steer, t;
        if (!g) begin
            m_frwrd = 0; m_integ = 0; m_hist = '{0, 0}; m_lft = 0; m_rght = 0;
        end else if (m_vldq) begin
            p = 3 * m_errq;
            d = 6 * msat(m_errq - m_hist[0], 7);
            i = I_EN ? (m_integ >>> 4) : 0;
            steer = (p + i + d) >>> 3;
            m_frwrd = (m_frwrd + INC > int'(FMAX)) ? int'(FMAX) : m_frwrd + INC;
            m_lft  = msat(m_frwrd + steer, 11);
            m_rght = msat(m_frwrd - steer, 11);
            if (I_EN) begin
                t = m_integ + m_errq;
                if (t >= -32768 && t <= 32767) m_integ = t;
            end
            void'(m_hist.pop_front());
            m_hist.push_back(m_errq);
        end
        if (v) m_errq = msat(lp ? e : o, 10);
        m_vldq = v;
    endtask

    task automatic chk(input string tag, input integer obs, input integer exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input bit g, input bit lp,
                       input logic signed [15:0] e, input logic signed [15:0] o);
        @(negedge clk);
        err_vld = v; go = g; line_present = lp; error = e; err_opn_lp = o;
        @(posedge clk);
        model_step(v, g, lp, int'(e), int'(o));
        #1;
        chk("lft_spd", lft_spd, m_lft);
        chk("rght_spd", rght_spd, m_rght);
        chk("moving", moving, (m_frwrd != 0) ? 1 : 0);
        chk("frwrd", dut.frwrd, m_frwrd);
    endtask

    initial begin
        int guard;
        model_reset();

        // reset and idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lft", lft_spd, 0);
        chk("rst_rght", rght_spd, 0);
        chk("rst_moving", moving, 0);
        chk("rst_errq", dut.err_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cyc(k == 2, 1'b0, 1'b1, 16'h0100, 16'h0000);
        chk("idle_errq", dut.err_q, 256);

        // steady error until the ramp tops out
        guard = 0;
        while (m_frwrd < int'(FMAX) && guard < 1000) begin
            cyc(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000);
            repeat (3) cyc(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000);
            guard++;
        end
        chk("ramp_bound", (guard < 1000) ? 1 : 0, 1);
        repeat (3) begin
            cyc(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000);
            cyc(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000);
        end
        chk("t2_frwrd", dut.frwrd, 768);
`ifndef PID_I_TERM_EN
        chk("t2_lft", lft_spd, 11'h318);
        chk("t2_rght", rght_spd, 11'h2E8);
`endif

        // input saturation
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b1, 16'h7FFF, 16'h0000);
        chk("t3_errq", dut.err_q, 511);
`ifdef PID_I_TERM_EN
        chk("t3_lft_clamp", lft_spd, 1023);
`endif

        // open-loop override path
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 1'b0, 16'h7FFF, -16'sh340);
        chk("t4_errq", dut.err_q, -512);
        chk("t4_rght_gt_lft", (rght_spd > lft_spd) ? 1 : 0, 1);

        // go drop coincident with vld_q
        cyc(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000);
        chk("t5_moving_before", moving, 1);
        cyc(1'b0, 1'b0, 1'b1, 16'h0040, 16'h0000);
        chk("t5_frwrd", dut.frwrd, 0);
        chk("t5_moving", moving, 0);
        chk("t5_lft", lft_spd, 0);
`ifdef PID_I_TERM_EN
        chk("t5_integ", dut.u_i.integ, 0);
`endif

        // long constant error: integrator must hold, not wrap
        for (int k = 0; k < 200; k++) begin
            cyc(1'b1, 1'b1, 1'b1, 16'h01FF, 16'h0000);
            cyc(1'b0, 1'b1, 1'b1, 16'h01FF, 16'h0000);
`ifdef PID_I_TERM_EN
            chk("t6_integ", dut.u_i.integ, m_integ);
            chk("t6_sign", dut.u_i.integ[15], 0);
`endif
        end
`ifdef PID_I_TERM_EN
        chk("t6_integ_final", dut.u_i.integ, 32704);
`endif

        // randomized operation
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0),
                1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end

        // asynchronous reset mid-operation
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lft", lft_spd, 0);
        chk("arst_rght", rght_spd, 0);
        chk("arst_moving", moving, 0);
        chk("arst_errq", dut.err_q, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            cyc(1'($urandom_range(0, 1)), 1'b1,
                1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
